// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage load/store engine and the memory.
// The unit drives the request side; the memory returns ack and read data.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one req/ack bus access per memory op,
// stalls the front of the pipe while it is outstanding, formats load data.
//
// state  | meaning
// IDLE   | no access outstanding; ALU ops pass straight through
// BUSY   | request on the bus, waiting for ack or timeout
// RESP   | one cycle where MEM/WB captures the completed result
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ex_result_in,
  input  logic [31:0]        store_data_in,
  input  logic [2:0]         funct3_in,
  input  logic [4:0]         rd_in,
  input  logic               mwr_in,
  input  logic               werf_in,
  input  logic               wb_sel_in,
  mem_access_unit_if.master  dmem,
  output logic [31:0]        ex_result_out,
  output logic [31:0]        mem_rdata_out,
  output logic [4:0]         rd_out,
  output logic               werf_out,
  output logic               wb_sel_out,
  output logic               stall_out,
  output logic               misalign_out,
  output logic               bus_err_out
);

  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      state, state_nxt;
  logic        req_q, we_q, bus_err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [CNT_W-1:0] cnt_q;

  logic        access, size_ok, addr_bad, illegal, start, timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_fmt;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign access   = mwr_in | wb_sel_in;
  assign addr_bad = ((funct3_in[1:0] == 2'b01) && ex_result_in[0]) ||
                    ((funct3_in[1:0] == 2'b10) && (ex_result_in[1:0] != 2'b00));
  assign illegal  = ~size_ok | addr_bad;
  assign start    = (state == S_IDLE) && access && !illegal;
  assign timeout  = (cnt_q == TC_LAST);

  always_comb begin
    size_ok = 1'b0;
    if (mwr_in)
      size_ok = funct3_in inside {3'b000, 3'b001, 3'b010};
    else
      size_ok = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << ex_result_in[1:0];
        wdata_calc = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << ex_result_in[1:0];
        wdata_calc = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched at issue, not the live inputs.
  always_comb begin
    lane_byte = dmem.dmem_rdata[7:0];
    case (off_q)
      2'd1:    lane_byte = dmem.dmem_rdata[15:8];
      2'd2:    lane_byte = dmem.dmem_rdata[23:16];
      2'd3:    lane_byte = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    lane_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_fmt = {24'd0, lane_byte};
      3'b101:  load_fmt = {16'd0, lane_half};
      default: load_fmt = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall_out    = 1'b0;
    werf_out     = 1'b0;
    misalign_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (!access) begin
          werf_out = werf_in;
        end else if (illegal) begin
          misalign_out = 1'b1;
        end else begin
          stall_out = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_out = 1'b1;
        if (dmem.dmem_ack || timeout) state_nxt = S_RESP;
      end
      S_RESP: begin
        werf_out  = werf_in & ~bus_err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= mwr_in;
        addr_q  <= {ex_result_in[31:2], 2'b00};
        be_q    <= be_calc;
        wdata_q <= wdata_calc;
        f3_q    <= funct3_in;
        off_q   <= ex_result_in[1:0];
        cnt_q   <= '0;
      end
      if (state == S_BUSY) begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (dmem.dmem_ack) begin
          req_q <= 1'b0;
          if (!we_q) rdata_q <= load_fmt;
        end else if (timeout) begin
          req_q     <= 1'b0;
          bus_err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (state == S_RESP) begin
        cnt_q     <= '0;
        bus_err_q <= 1'b0;
      end
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign ex_result_out = ex_result_in;
  assign rd_out        = rd_in;
  assign wb_sel_out    = wb_sel_in;
  assign mem_rdata_out = rdata_q;
  assign bus_err_out   = bus_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine that consumes the EX/MEM pipeline register outputs and drives the data-memory bus through a req/ack handshake.
- Formats load data and generates byte enables and lane-replicated write data.
- Stalls the front of the pipe while an access is outstanding.
- Results feed the MEM/WB register: pass-through fields plus a registered load-data word.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without dmem_ack before the access is aborted with a bus error.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk rising edge).
- ex_result_in  in  32  effective address for memory ops; ALU result otherwise.
- store_data_in  in  32  rs2 value for stores.
- funct3_in  in  3  access size/sign.
- rd_in  in  5  destination register.
- mwr_in  in  1  store.
- werf_in  in  1  register-file write enable.
- wb_sel_in  in  1  1 = load (write back memory data).
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write.
- dmem_addr  out  32  word address, bits[1:0]=0.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  bus completion.
- dmem_rdata  in  32  read word.
- ex_result_out  out  32  ex_result_in pass-through.
- mem_rdata_out  out  32  formatted load data.
- rd_out  out  5  rd_in pass-through.
- werf_out  out  1  gated write enable.
- wb_sel_out  out  1  wb_sel_in pass-through.
- stall_out  out  1  hold upstream stages and the EX/MEM register.
- misalign_out  out  1  misaligned or illegal-size access.
- bus_err_out  out  1  access aborted by timeout.

Behaviour:
- access = mwr_in | wb_sel_in. Legal sizes:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - any other funct3 with access set is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, BUSY, RESP. Reset: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, mem_rdata_out=0, counter=0, bus_err_out=0.
- IDLE:
  - access=0: combinational pass-through, zero latency, stall_out=0.
  - access=1 and legal/aligned:
    - stall_out=1 combinationally.
    - Register dmem_addr={addr[31:2],2'b00}, dmem_we=mwr_in, dmem_be, dmem_wdata, latched funct3 and addr[1:0].
    - dmem_req=1 from the next cycle; go to BUSY.
  - access=1 and illegal/misaligned: no request, misalign_out=1 (combinational, same cycle), werf_out=0, stall_out=0, remain IDLE.
- Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
- Write data: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
- BUSY:
  - stall_out=1; dmem_req and all dmem_* outputs held stable; counter increments each cycle.
  - On dmem_ack:
    - For loads, capture dmem_rdata into mem_rdata_out: select the lane by the latched addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word unchanged.
    - Clear dmem_req at the clock edge; go to RESP.
  - Timeout: counter reaches TIMEOUT_CYCLES-1 without ack → clear dmem_req, set bus_err_out=1, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP (exactly one cycle):
  - stall_out=0; the MEM/WB register captures the outputs this cycle.
  - werf_out = werf_in & ~bus_err_out.
  - Next state IDLE; clear counter and bus_err_out.
  - Inputs in RESP still show the completed instruction and must not retrigger an access.
- Latency: store 3 cycles (IDLE→BUSY→RESP) with 1-cycle ack; load data valid in RESP.
- mem_rdata_out holds its value until the next load capture.
- dmem_ack outside BUSY is ignored.
- rst==0 in any state: IDLE next edge, dmem_req=0 next cycle, outstanding access abandoned; rst takes priority over dmem_ack in the same cycle.
- ex_result_out, rd_out and wb_sel_out are always combinational pass-throughs.

Test Plan:
- LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF:
  - dmem_addr=0x100, be=1111, stall_out high for 3 cycles.
  - RESP: mem_rdata_out=0xDEADBEEF, werf_out=1.
- LB addr 0x103, rdata 0x80FF_FF00 → mem_rdata_out=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH addr 0x206, data 0x1234ABCD, 1-cycle ack:
  - dmem_addr=0x204, be=1100, wdata=0xABCDABCD, dmem_we=1.
  - Exactly one req pulse sequence.
- LW addr 0x102 → misalign_out=1, werf_out=0, no dmem_req, stall_out=0. Same for funct3=011.
- No ack for TIMEOUT_CYCLES=4 → dmem_req drops after 4 BUSY cycles; RESP shows bus_err_out=1, werf_out=0.
- rst=0 during BUSY with dmem_ack=1 the same cycle → next cycle IDLE, dmem_req=0, mem_rdata_out=0, stall_out=0. Then an ALU op (access=0) passes through with no stall.
